// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing, forwarding-select encodings and latency helper for the issue-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS    = 8;
    localparam int ADDR_W      = 3;
    localparam int LAT_W       = 2;
    localparam int STALL_CNT_W = 8;

    localparam logic FWD_SEL_WB = 1'b0;
    localparam logic FWD_SEL_RF = 1'b1;

    typedef logic [LAT_W-1:0]  countT;
    typedef logic [ADDR_W-1:0] regAddrT;

    // A zero latency request is treated as the fastest legal one.
    function automatic countT effLatency(input countT lat);
        return (lat == '0) ? LAT_W'(1) : lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_countdown.sv
// Per-register writeback countdown: load wins over decrement, clear wins over load; flags are combinational.
// Zero latency on flags; no backpressure (state advances every cycle).
module reg_countdown
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [LAT_W-1:0] loadVal,
    output logic [LAT_W-1:0] count,
    output logic             isIdle,
    output logic             isReady,
    output logic             isPending
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

    assign isIdle    = (count == '0);
    assign isReady   = (count == LAT_W'(1));
    assign isPending = (count > LAT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: per-register writeback countdowns, RAW/WAW stall, EX forwarding selects, WB check.
// Stall and forwarding selects are combinational from current state; stalled issue is held upstream.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic [LAT_W-1:0]       issue_lat,
    input  logic                   issue_use_a,
    input  logic [ADDR_W-1:0]      issue_rs_a,
    input  logic                   issue_use_b,
    input  logic [ADDR_W-1:0]      issue_rs_b,
    input  logic                   flush,
    input  logic                   wb_we,
    input  logic [ADDR_W-1:0]      wb_addr,
    output logic                   stall,
    output logic                   fwd_sel_a,
    output logic                   fwd_sel_b,
    output logic [NUM_REGS-1:0]    busy,
    output logic                   sb_error,
    output logic [STALL_CNT_W-1:0] stall_count
);

    countT               regCount [NUM_REGS];
    logic [NUM_REGS-1:0] idleVec;
    logic [NUM_REGS-1:0] readyVec;
    logic [NUM_REGS-1:0] pendingVec;
    logic [NUM_REGS-1:0] loadVec;
    logic [NUM_REGS-1:0] wbMatch;

    countT latEff;
    logic  rawA;
    logic  rawB;
    logic  waw;
    logic  accept;
    logic  missedWb;

    assign latEff = effLatency(issue_lat);

    // A ready operand (count 1) is covered by the WB bypass, so only pending ones stall.
    assign rawA   = issue_use_a && pendingVec[issue_rs_a];
    assign rawB   = issue_use_b && pendingVec[issue_rs_b];
    assign waw    = issue_we && (regCount[issue_rd] > latEff);
    assign stall  = issue_valid && !flush && (rawA || rawB || waw);
    assign accept = issue_valid && !stall && !flush;

    assign fwd_sel_a = (issue_use_a && readyVec[issue_rs_a]) ? FWD_SEL_WB : FWD_SEL_RF;
    assign fwd_sel_b = (issue_use_b && readyVec[issue_rs_b]) ? FWD_SEL_WB : FWD_SEL_RF;
    assign busy      = ~idleVec;

    for (genvar r = 0; r < NUM_REGS; r++) begin : gCount
        assign loadVec[r] = accept && issue_we && (issue_rd == ADDR_W'(r));
        assign wbMatch[r] = wb_we && (wb_addr == ADDR_W'(r));

        reg_countdown uCount (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush),
            .load      (loadVec[r]),
            .loadVal   (latEff),
            .count     (regCount[r]),
            .isIdle    (idleVec[r]),
            .isReady   (readyVec[r]),
            .isPending (pendingVec[r])
        );
    end

    // Any register due this cycle without a matching WB write is a lost result.
    assign missedWb = !flush && |(readyVec & ~wbMatch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_error <= 1'b0;
        end else if (missedWb) begin
            sb_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-scenario tasks, queued expectations, auto WB driver.
module tb_hazard_scoreboard;

    typedef struct {
        logic        v;
        logic        we;
        logic [2:0]  rd;
        logic [1:0]  lat;
        logic        ua;
        logic [2:0]  ra;
        logic        ub;
        logic [2:0]  rb;
        logic        fl;
        logic [11:0] exp;   // {stall, fwd_sel_a, fwd_sel_b, busy[7:0], sb_error}
    } stepT;

    typedef struct {
        logic [2:0] addr;
        int         due;
    } wbEntryT;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic       issue_we;
    logic [2:0] issue_rd;
    logic [1:0] issue_lat;
    logic       issue_use_a;
    logic [2:0] issue_rs_a;
    logic       issue_use_b;
    logic [2:0] issue_rs_b;
    logic       flush;
    logic       wb_we;
    logic [2:0] wb_addr;
    logic       stall;
    logic       fwd_sel_a;
    logic       fwd_sel_b;
    logic [7:0] busy;
    logic       sb_error;
    logic [7:0] stall_count;

    int          nAssert = 0;
    int          nFail   = 0;
    int          cyc     = 0;
    bit          noWb    = 0;
    logic [11:0] expQ[$];
    wbEntryT     wbQ[$];

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .issue_use_a (issue_use_a),
        .issue_rs_a  (issue_rs_a),
        .issue_use_b (issue_use_b),
        .issue_rs_b  (issue_rs_b),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .stall       (stall),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .busy        (busy),
        .sb_error    (sb_error),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Writeback driver: puts each scheduled result on the WB bus in its due cycle.
    initial begin
        wb_we   = 1'b0;
        wb_addr = 3'd0;
        forever begin
            @(posedge clk);
            #2;
            wb_we   = 1'b0;
            wb_addr = 3'd0;
            for (int i = wbQ.size() - 1; i >= 0; i--) begin
                if (wbQ[i].due <= cyc) begin
                    if (wbQ[i].due == cyc && !noWb) begin
                        wb_we   = 1'b1;
                        wb_addr = wbQ[i].addr;
                    end
                    wbQ.delete(i);
                end
            end
        end
    end

    function automatic stepT mk(input logic v, input logic we, input logic [2:0] rd,
                                input logic [1:0] lat, input logic ua, input logic [2:0] ra,
                                input logic ub, input logic [2:0] rb, input logic fl,
                                input logic es, input logic efa, input logic efb,
                                input logic [7:0] eb, input logic ee);
        stepT s;
        s.v = v;  s.we = we; s.rd = rd; s.lat = lat;
        s.ua = ua; s.ra = ra; s.ub = ub; s.rb = rb; s.fl = fl;
        s.exp = {es, efa, efb, eb, ee};
        return s;
    endfunction

    function automatic stepT idle(input logic [7:0] eb, input logic ee);
        return mk(0, 0, 3'd0, 2'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, eb, ee);
    endfunction

    // Drives one issue cycle, records its expected outputs and any writeback it will owe.
    task automatic applyStep(input stepT s);
        issue_valid = s.v;
        issue_we    = s.we;
        issue_rd    = s.rd;
        issue_lat   = s.lat;
        issue_use_a = s.ua;
        issue_rs_a  = s.ra;
        issue_use_b = s.ub;
        issue_rs_b  = s.rb;
        flush       = s.fl;
        if (s.fl) begin
            wbQ.delete();
        end else if (s.v && s.we && !s.exp[11]) begin
            wbQ.push_back('{addr: s.rd, due: cyc + ((s.lat == 2'd0) ? 1 : int'(s.lat))});
        end
        expQ.push_back(s.exp);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStep(idle(8'h00, 1'b0));
        void'(expQ.pop_back());
        wbQ.delete();
        expQ.delete();
        noWb = 0;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        logic [11:0] e;
        reset = 1'b1;
        applyStep(idle(8'h00, 1'b0));
        #1;
        e   = expQ.pop_front();
        got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
        nAssert++;
        if (got !== e) begin
            nFail++;
            $display("FAIL reset_state: got %h, expected %h", got, e);
        end
        nAssert++;
        if (stall_count !== 8'd0) begin
            nFail++;
            $display("FAIL reset_stall_count: got %0d, expected 0", stall_count);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw_lat1();
        stepT st[3];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        st[0] = mk(1, 1, 3'd3, 2'd1, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1] = mk(1, 0, 3'd0, 2'd0, 1, 3'd3, 0, 3'd0, 0, 0, 0, 1, 8'h08, 0);
        st[2] = mk(1, 0, 3'd0, 2'd0, 1, 3'd3, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL raw_lat1 step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_raw_lat3();
        stepT st[5];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        st[0] = mk(1, 1, 3'd5, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1] = mk(1, 0, 3'd0, 2'd0, 1, 3'd5, 0, 3'd0, 0, 1, 1, 1, 8'h20, 0);
        st[2] = mk(1, 0, 3'd0, 2'd0, 1, 3'd5, 0, 3'd0, 0, 1, 1, 1, 8'h20, 0);
        st[3] = mk(1, 0, 3'd0, 2'd0, 1, 3'd5, 0, 3'd0, 0, 0, 0, 1, 8'h20, 0);
        st[4] = idle(8'h00, 0);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL raw_lat3 step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
        nAssert++;
        if (stall_count !== 8'd2) begin
            nFail++;
            $display("FAIL raw_lat3_stall_count: got %0d, expected 2", stall_count);
        end
    endtask

    task automatic test_waw();
        stepT st[12];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        st[0]  = mk(1, 1, 3'd2, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1]  = mk(1, 1, 3'd2, 2'd1, 0, 3'd0, 0, 3'd0, 0, 1, 1, 1, 8'h04, 0);
        st[2]  = mk(1, 1, 3'd2, 2'd1, 0, 3'd0, 0, 3'd0, 0, 1, 1, 1, 8'h04, 0);
        st[3]  = mk(1, 1, 3'd2, 2'd1, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h04, 0);
        st[4]  = idle(8'h04, 0);
        st[5]  = mk(1, 1, 3'd2, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[6]  = idle(8'h04, 0);
        st[7]  = mk(1, 1, 3'd2, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h04, 0);
        st[8]  = mk(1, 0, 3'd0, 2'd0, 1, 3'd2, 0, 3'd0, 0, 1, 1, 1, 8'h04, 0);
        st[9]  = mk(1, 0, 3'd0, 2'd0, 1, 3'd2, 0, 3'd0, 0, 1, 1, 1, 8'h04, 0);
        st[10] = mk(1, 0, 3'd0, 2'd0, 1, 3'd2, 0, 3'd0, 0, 0, 0, 1, 8'h04, 0);
        st[11] = idle(8'h00, 0);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL waw step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
        nAssert++;
        if (stall_count !== 8'd4) begin
            nFail++;
            $display("FAIL waw_stall_count: got %0d, expected 4", stall_count);
        end
    endtask

    task automatic test_flush();
        stepT st[6];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        st[0] = mk(1, 1, 3'd1, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1] = mk(1, 1, 3'd4, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h02, 0);
        st[2] = mk(1, 0, 3'd0, 2'd0, 1, 3'd1, 1, 3'd4, 0, 1, 1, 1, 8'h12, 0);
        st[3] = mk(1, 1, 3'd5, 2'd1, 1, 3'd1, 1, 3'd4, 1, 0, 0, 1, 8'h12, 0);
        st[4] = mk(1, 0, 3'd0, 2'd0, 1, 3'd1, 1, 3'd4, 0, 0, 1, 1, 8'h00, 0);
        st[5] = idle(8'h00, 0);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL flush step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
        nAssert++;
        if (stall_count !== 8'd1) begin
            nFail++;
            $display("FAIL flush_stall_count: got %0d, expected 1", stall_count);
        end
    endtask

    task automatic test_error();
        stepT st[6];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        noWb  = 1;
        st[0] = mk(1, 1, 3'd6, 2'd2, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1] = idle(8'h40, 0);
        st[2] = idle(8'h40, 0);
        st[3] = idle(8'h00, 1);
        st[4] = idle(8'h00, 1);
        st[5] = idle(8'h00, 1);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL error step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
        noWb = 0;
    endtask

    // Entered with sb_error still set from the error scenario.
    task automatic test_reset_midstream();
        stepT st[2];
        logic [11:0] got;
        logic [11:0] e;
        st[0] = mk(1, 1, 3'd3, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 1);
        st[1] = mk(1, 0, 3'd0, 2'd0, 1, 3'd3, 1, 3'd3, 0, 1, 1, 1, 8'h08, 1);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL reset_mid step %0d: got %h, expected %h", i, got, e);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        reset = 1'b1;
        wbQ.delete();
        expQ.push_back({1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
        #1;
        e   = expQ.pop_front();
        got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
        nAssert++;
        if (got !== e) begin
            nFail++;
            $display("FAIL reset_mid_async: got %h, expected %h", got, e);
        end
        nAssert++;
        if (stall_count !== 8'd0) begin
            nFail++;
            $display("FAIL reset_mid_stall_count: got %0d, expected 0", stall_count);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            applyStep(idle(8'h00, 0));
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL reset_mid_after step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stepT st[7];
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        st[0] = mk(1, 1, 3'd1, 2'd3, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[1] = mk(1, 1, 3'd2, 2'd1, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h02, 0);
        st[2] = mk(1, 0, 3'd0, 2'd0, 1, 3'd1, 1, 3'd2, 0, 1, 1, 0, 8'h06, 0);
        st[3] = mk(1, 0, 3'd0, 2'd0, 1, 3'd1, 1, 3'd2, 0, 0, 0, 1, 8'h02, 0);
        st[4] = mk(1, 1, 3'd7, 2'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
        st[5] = mk(1, 0, 3'd0, 2'd0, 1, 3'd7, 0, 3'd0, 0, 0, 0, 1, 8'h80, 0);
        st[6] = idle(8'h00, 0);
        foreach (st[i]) begin
            applyStep(st[i]);
            @(negedge clk);
            e   = expQ.pop_front();
            got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
            nAssert++;
            if (got !== e) begin
                nFail++;
                $display("FAIL back_to_back step %0d: got %h, expected %h", i, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Read-and-rewrite r0 at latency 3 each round: one accept then two stalls.
    task automatic test_stall_saturation();
        stepT        s;
        logic [11:0] got;
        logic [11:0] e;
        doReset();
        for (int r = 0; r < 130; r++) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 0 && r == 0)
                    s = mk(1, 1, 3'd0, 2'd3, 1, 3'd0, 0, 3'd0, 0, 0, 1, 1, 8'h00, 0);
                else if (k == 0)
                    s = mk(1, 1, 3'd0, 2'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0, 1, 8'h01, 0);
                else
                    s = mk(1, 1, 3'd0, 2'd3, 1, 3'd0, 0, 3'd0, 0, 1, 1, 1, 8'h01, 0);
                applyStep(s);
                @(negedge clk);
                e   = expQ.pop_front();
                got = {stall, fwd_sel_a, fwd_sel_b, busy, sb_error};
                nAssert++;
                if (got !== e) begin
                    nFail++;
                    $display("FAIL stall_sat round %0d step %0d: got %h, expected %h", r, k, got, e);
                end
                @(posedge clk);
                #1;
            end
            if (r == 99) begin
                nAssert++;
                if (stall_count !== 8'd200) begin
                    nFail++;
                    $display("FAIL stall_count_200: got %0d, expected 200", stall_count);
                end
            end
        end
        nAssert++;
        if (stall_count !== 8'd255) begin
            nFail++;
            $display("FAIL stall_count_sat: got %0d, expected 255", stall_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = 3'd0;
        issue_lat   = 2'd0;
        issue_use_a = 1'b0;
        issue_rs_a  = 3'd0;
        issue_use_b = 1'b0;
        issue_rs_b  = 3'd0;
        flush       = 1'b0;
        test_reset();
        test_raw_lat1();
        test_raw_lat3();
        test_waw();
        test_flush();
        test_error();
        test_reset_midstream();
        test_back_to_back();
        test_stall_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
